fifo_uart_tx: RTL



---
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read port of a standard synchronous FIFO (1-cycle read
// latency) as seen by a draining consumer.
//   master : the consumer that pops (fifo_uart_tx)
//   slave  : the FIFO that owns the data
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO one byte at a time and serialises
// each byte as 8N1 UART (LSB first) on tx.
//
// Frame, relative to the pop strobe in cycle T:
//   T      : fifo_rd_en high (state IDLE)
//   T+1    : LOAD, fifo_rd_data captured
//   T+2 .. : START, 8 x DATA, [PARITY], STOP, each DIV cycles
// Consecutive pops are spaced (10*DIV)+2 cycles apart, or (11*DIV)+2 with
// parity enabled.
//
// Build option:
//   UART_PARITY_EN - when defined, an even-parity bit (XOR of the 8 data
//                    bits) is sent between the last data bit and STOP.
//                    When undefined, no parity state or logic exists.
//
// All outputs are registered: each is computed from the next state so that
// it changes together with the state it belongs to.
module fifo_uart_tx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = CLK_HZ / BAUD   // cycles per bit, must be >= 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);

  localparam int                CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q,  baud_d;
  logic [2:0]       bit_q,   bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_d;
  logic             rd_en_d;
  logic             busy_d;
  logic             baud_last;

`ifdef UART_PARITY_EN
  logic             parity_q;
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; a missed branch would otherwise infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;

    unique case (state_q)
      IDLE: begin
        // The pop strobe was issued for this cycle; data arrives next cycle.
        if (fifo.fifo_rd_en) state_d = LOAD;
      end

      LOAD: begin
        shreg_d = fifo.fifo_rd_data;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered pop strobe: decided on the cycle whose next state is IDLE,
    // so it is high during an IDLE cycle. Deciding in the last STOP cycle is
    // what lets back-to-back frames run at the minimum (frame + 2) spacing.
    rd_en_d = (state_d == IDLE) && enable && !fifo.fifo_empty;

    // Line level belonging to the state about to be entered.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      baud_q          <= '0;
      bit_q           <= '0;
      shreg_q         <= '0;
      tx              <= 1'b1;
      fifo.fifo_rd_en <= 1'b0;
      busy            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q         <= state_d;
      baud_q          <= baud_d;
      bit_q           <= bit_d;
      shreg_q         <= shreg_d;
      tx              <= tx_d;
      fifo.fifo_rd_en <= rd_en_d;
      busy            <= busy_d;
    end
  end

`ifdef UART_PARITY_EN
  // Even parity of the byte, captured alongside the shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (state_q == LOAD) begin
      parity_q <= ^fifo.fifo_rd_data;
    end
  end
`endif

  // Simulation-only invariants of the pop handshake and status outputs.
  a_pop_only_in_idle : assert property (
    @(posedge clk) disable iff (rst) fifo.fifo_rd_en |-> (state_q == IDLE));

  a_pop_one_cycle : assert property (
    @(posedge clk) disable iff (rst) fifo.fifo_rd_en |=> !fifo.fifo_rd_en);

  a_busy_tracks_state : assert property (
    @(posedge clk) disable iff (rst) busy == (state_q != IDLE));

  a_idle_line_high : assert property (
    @(posedge clk) disable iff (rst) (state_q == IDLE) |-> tx);

endmodule
